// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte register file, auto-incrementing pointer,
// burst read/write, repeated START/STOP handling and a host peek port.
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         REG_DEPTH   = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = $clog2(REG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_scl,
    inout  wire           io_sda,
    output logic          o_sda_mode,
    input  logic [AW-1:0] i_host_addr,
    output logic [7:0]    o_host_data,
    output logic          o_wr_pulse,
    output logic [AW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_data,
    output logic          o_busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic scl_d, sda_d;
    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [3:0] cnt, cnt_n;
    logic [7:0] shift, shift_n;
    logic [AW-1:0] ptr, ptr_n;
    logic rw, rw_n;
    logic sda_mode_n, busy_n, wr_en;

    logic [REG_DEPTH-1:0][7:0] regs;

    assign io_sda = o_sda_mode ? 1'bz : 1'b0;
    assign o_host_data = regs[i_host_addr];

    assign scl_s = scl_q[SYNC_STAGES-1];
    assign sda_s = sda_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_q      <= '1;
            sda_q      <= '1;
            scl_d      <= 1'b1;
            sda_d      <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= '0;
            shift      <= '0;
            ptr        <= '0;
            rw         <= 1'b0;
            o_sda_mode <= 1'b1;
            o_busy     <= 1'b0;
            o_wr_pulse <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            regs       <= '0;
        end else begin
            scl_q      <= {scl_q[SYNC_STAGES-2:0], i_scl};
            sda_q      <= {sda_q[SYNC_STAGES-2:0], io_sda};
            scl_d      <= scl_s;
            sda_d      <= sda_s;
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            ptr        <= ptr_n;
            rw         <= rw_n;
            o_sda_mode <= sda_mode_n;
            o_busy     <= busy_n;
            o_wr_pulse <= wr_en;
            if (wr_en) begin
                regs[ptr] <= shift;
                o_wr_addr <= ptr;
                o_wr_data <= shift;
            end
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shift_n    = shift;
        ptr_n      = ptr;
        rw_n       = rw;
        sda_mode_n = o_sda_mode;
        busy_n     = o_busy;
        wr_en      = 1'b0;
        // Bus conditions override any bit-level activity in the same clk
        if (start_det) begin
            state_n    = ST_DEV_ADDR;
            cnt_n      = '0;
            sda_mode_n = 1'b1;
            busy_n     = 1'b1;
        end else if (stop_det) begin
            state_n    = ST_IDLE;
            sda_mode_n = 1'b1;
            busy_n     = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_DEV_ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_s};
                        cnt_n   = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        cnt_n = '0;
                        if (shift[7:1] == DEV_ADDR) begin
                            sda_mode_n = 1'b0;
                            rw_n       = shift[0];
                            state_n    = ST_DEV_ACK;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            shift_n    = regs[ptr];
                            sda_mode_n = regs[ptr][7];
                            cnt_n      = 4'd1;
                            state_n    = ST_RD_DATA;
                        end else begin
                            sda_mode_n = 1'b1;
                            cnt_n      = '0;
                            state_n    = ST_REG_ADDR;
                        end
                    end
                end
                ST_REG_ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_s};
                        cnt_n   = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        ptr_n      = shift[AW-1:0];
                        sda_mode_n = 1'b0;
                        cnt_n      = '0;
                        state_n    = ST_REG_ACK;
                    end
                end
                ST_REG_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_mode_n = 1'b1;
                        cnt_n      = '0;
                        state_n    = ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_s};
                        cnt_n   = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        wr_en      = 1'b1;
                        ptr_n      = ptr + 1'b1;
                        sda_mode_n = 1'b0;
                        cnt_n      = '0;
                        state_n    = ST_WR_ACK;
                    end
                end
                ST_RD_DATA: begin
                    // cnt holds the number of bits already placed on the bus
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_mode_n = 1'b1;
                            state_n    = ST_RD_ACK;
                        end else begin
                            sda_mode_n = shift[6];
                            shift_n    = {shift[6:0], 1'b0};
                            cnt_n      = cnt + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            busy_n  = 1'b0;
                            state_n = ST_IDLE;
                        end else begin
                            ptr_n = ptr + 1'b1;
                        end
                    end else if (scl_fall) begin
                        shift_n    = regs[ptr];
                        sda_mode_n = regs[ptr][7];
                        cnt_n      = 4'd1;
                        state_n    = ST_RD_DATA;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule
